desempaquetador_pixeles: RTL and testbench
==========================================

# desempaquetador_pixeles

Parametrised successor to the two-group pixel buffer. Accepts memory words of `MEM_WORD_BITS` into a `DEPTH_WORDS`-deep word FIFO and presents them one pixel at a time to the filter datapath. It adds the following behaviour:

- per-word selectable pixel order (MSB-first or LSB-first);
- explicit full/empty flags and an occupancy count;
- simultaneous load/consume at full;
- synchronous flush;
- sticky overflow and underflow error flags.

It sits between the memory read controller and the window/filter pipeline.

## Interface

Parameters:
- `MEM_WORD_BITS`, 32, width of one memory word.
- `PIXEL_BITS`, 8, width of one pixel. `MEM_WORD_BITS` must be an exact multiple of it.
- `DEPTH_WORDS`, 2, FIFO depth in words. Must be a power of two, ≥ 2.
- Derived, not overridable:
  - `PIX_PER_WORD` = `MEM_WORD_BITS/PIXEL_BITS`
  - `CNT_BITS` = clog2(`DEPTH_WORDS`+1)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous clear of all buffered data and error flags.
- `memory_data`  in  `MEM_WORD_BITS`  word from memory.
- `save_mem_data`  in  1  write strobe for `memory_data`.
- `orden_lsb`  in  1  pixel order of the word being written: 0 = MSB-first, 1 = LSB-first. Sampled with `save_mem_data` and stored per word.
- `read_pixel`  in  1  consume the pixel currently on `pixel`.
- `pixel`  out  `PIXEL_BITS`  current pixel, combinational from head word, its stored order bit, and the pixel index.
- `pixel_valid`  out  1  FIFO non-empty.
- `word_ready`  out  1  FIFO not full.
- `words_stored`  out  `CNT_BITS`  number of words held, including a partially consumed head word.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read occurred while empty.

## Operation

Storage:
- Word RAM/registers of `DEPTH_WORDS` × (`MEM_WORD_BITS`+1); the extra bit is the order bit.
- Write pointer, read pointer, occupancy counter, and a pixel index `idx` (0..`PIX_PER_WORD`-1).

Occupancy conditions (derived from the count, no separate FSM register):
- VACIO: count 0.
- PARCIAL: count between 0 and `DEPTH_WORDS`, exclusive.
- LLENO: count = `DEPTH_WORDS`.

Pixel selection:
- MSB-first: `idx` k selects bits [`MEM_WORD_BITS`-1-k·`PIXEL_BITS` -: `PIXEL_BITS`].
- LSB-first: `idx` k selects bits [k·`PIXEL_BITS` +: `PIXEL_BITS`].
- `pixel` is forced to 0 when VACIO.

Read:
- Accepted when `read_pixel`=1 and `pixel_valid`=1.
- `idx` increments.
- When `idx` = `PIX_PER_WORD`-1, `idx` wraps to 0 and the head word pops: read pointer +1 modulo `DEPTH_WORDS`, count −1.

Write:
- Accepted when `save_mem_data`=1 and either (`word_ready`=1) or (a pop occurs in the same cycle).
- Stores `memory_data` and `orden_lsb` at the write pointer; write pointer +1 (wraps); count +1.

Simultaneous write and pop: both take effect and the count is unchanged. At LLENO this is a legal accept.

Error conditions:
- A write that is not accepted drops the word and sets `overflow`.
- `read_pixel` while VACIO sets `underflow`. State is otherwise unchanged.

Flush and reset:
- Priority: `reset` low > `flush` > read/write.
- `flush`=1 clears pointers, count, `idx`, `overflow` and `underflow`. Any write or read in that cycle is ignored.
- Reset values:
  - `pixel_valid`=0, `word_ready`=1, `words_stored`=0, `pixel`=0;
  - `overflow`=0, `underflow`=0;
  - internal pointers and `idx` = 0.
- Data storage is not cleared.
- Reset asserted mid-word discards the partial word.

## Timing

- Write-to-valid latency is 1 cycle: a word accepted at edge N makes `pixel_valid`=1 and the first pixel visible after edge N.
- `pixel` changes combinationally after each accepted read edge. One pixel per cycle is sustainable indefinitely when writes keep pace.
- `word_ready` and `words_stored` reflect post-edge state. `word_ready` deasserts the cycle after the count reaches `DEPTH_WORDS`.
- No combinational path from `read_pixel` or `save_mem_data` to any output.
- Error flags assert 1 cycle after the offending strobe.

## Test plan

1. **Reset.** Drive `reset`=0 for 2 cycles, then 1 → `pixel_valid`=0, `word_ready`=1, `words_stored`=0, `pixel`=0x00, `overflow`=0, `underflow`=0.
2. **MSB-first word.** Write 0xAABBCCDD with `orden_lsb`=0, then `read_pixel` for 4 consecutive cycles → `pixel` = 0xAA, 0xBB, 0xCC, 0xDD. After the 4th read: `pixel_valid`=0, `words_stored`=0.
3. **LSB-first word.** Write 0x11223344 with `orden_lsb`=1, then 0x55667788 with `orden_lsb`=0; read 8 → 0x44, 0x33, 0x22, 0x11, 0x55, 0x66, 0x77, 0x88.
4. **Overflow.** `DEPTH_WORDS`=2; write 3 words with no reads → `word_ready`=0 after the 2nd write, 3rd word dropped, `overflow`=1, `words_stored`=2; reads return only the first two words.
5. **Write at full with pop.** At LLENO, read the head's 4th pixel in the same cycle as writing 0xDEADBEEF → write accepted, `words_stored` stays 2, `overflow`=0; 0xDEADBEEF emerges after the remaining word.
6. **Flush, underflow, reset mid-word.**
   - After 2 reads of a word, assert `flush` together with `save_mem_data` → `words_stored`=0, `pixel_valid`=0, the write is ignored.
   - Then `read_pixel` → `underflow`=1.
   - Then `reset` low → `underflow`=0.

Source files
------------

// File: rtl/desempaquetador_pixeles.sv
`default_nettype none
// ============================================================================
// Module   : desempaquetador_pixeles
// Purpose  : Word FIFO that unpacks memory words into pixels, per-word order.
// Revision : 1.0
// ============================================================================
module desempaquetador_pixeles #(
   parameter int MEM_WORD_BITS = 32,
   parameter int PIXEL_BITS    = 8,
   parameter int DEPTH_WORDS   = 2,
   localparam int PIX_PER_WORD = MEM_WORD_BITS / PIXEL_BITS,
   localparam int CNT_BITS     = $clog2(DEPTH_WORDS + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [MEM_WORD_BITS-1:0] memory_data,
   input  logic                     save_mem_data,
   input  logic                     orden_lsb,
   input  logic                     read_pixel,
   output logic [PIXEL_BITS-1:0]    pixel,
   output logic                     pixel_valid,
   output logic                     word_ready,
   output logic [CNT_BITS-1:0]      words_stored,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PTR_BITS = $clog2(DEPTH_WORDS);
   localparam int IDX_BITS = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PIX_PER_WORD - 1);
   localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH_WORDS);

   // Bit MEM_WORD_BITS of each entry holds that word's order flag.
   logic [MEM_WORD_BITS:0] mem_q [DEPTH_WORDS];

   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic                   w_empty;
   logic                   w_rd_acc;
   logic                   w_pop;
   logic                   w_wr_acc;
   logic [MEM_WORD_BITS:0] w_head;
   logic [IDX_BITS-1:0]    w_slot;
   logic [PIXEL_BITS-1:0]  w_pix;

   assign w_empty  = (cnt_q == '0);
   assign w_rd_acc = read_pixel && !w_empty;
   assign w_pop    = w_rd_acc && (idx_q == LAST_IDX);
   assign w_wr_acc = save_mem_data && ((cnt_q != FULL_CNT) || w_pop);
   assign w_head   = mem_q[rd_ptr_q];

   // Slot counts pixel lanes from the LSB end of the word.
   assign w_slot = w_head[MEM_WORD_BITS] ? idx_q : (LAST_IDX - idx_q);

   always_comb begin
      w_pix = '0;
      for (int k = 0; k < PIX_PER_WORD; k++) begin
         if (IDX_BITS'(k) == w_slot) begin
            w_pix = w_head[k*PIXEL_BITS +: PIXEL_BITS];
         end
      end
   end

   assign pixel        = w_empty ? '0 : w_pix;
   assign pixel_valid  = !w_empty;
   assign word_ready   = (cnt_q != FULL_CNT);
   assign words_stored = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         idx_d    = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (w_rd_acc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_BITS'(1);
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         end
         if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
         end
         case ({w_wr_acc, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
            2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
            default: cnt_d = cnt_q;
         endcase
         if (save_mem_data && !w_wr_acc) begin
            ovf_d = 1'b1;
         end
         if (read_pixel && w_empty) begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is deliberately left uncleared by reset and flush.
   always_ff @(posedge clk) begin
      if (reset && !flush && w_wr_acc) begin
         mem_q[wr_ptr_q] <= {orden_lsb, memory_data};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_desempaquetador_pixeles.sv
`default_nettype none
// ============================================================================
// Module   : tb_desempaquetador_pixeles
// Purpose  : Directed self-checking bench for desempaquetador_pixeles.
// Revision : 1.0
// ============================================================================
module tb_desempaquetador_pixeles;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] memory_data = '0;
   logic        save_mem_data = 1'b0;
   logic        orden_lsb = 1'b0;
   logic        read_pixel = 1'b0;
   logic [7:0]  pixel;
   logic        pixel_valid;
   logic        word_ready;
   logic [1:0]  words_stored;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   desempaquetador_pixeles #(
      .MEM_WORD_BITS(32),
      .PIXEL_BITS(8),
      .DEPTH_WORDS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .memory_data(memory_data),
      .save_mem_data(save_mem_data),
      .orden_lsb(orden_lsb),
      .read_pixel(read_pixel),
      .pixel(pixel),
      .pixel_valid(pixel_valid),
      .word_ready(word_ready),
      .words_stored(words_stored),
      .overflow(overflow),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] d, input logic lsb);
      memory_data   = d;
      orden_lsb     = lsb;
      save_mem_data = 1'b1;
      tick();
      save_mem_data = 1'b0;
   endtask

   task automatic read_expect(input string name, input logic [7:0] exp [], input int n);
      for (int i = 0; i < n; i++) begin
         checks++;
         if (pixel !== exp[i] || pixel_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] pixel=%h valid=%b expected pixel=%h valid=1",
                     name, i, pixel, pixel_valid, exp[i]);
         end
         read_pixel = 1'b1;
         tick();
         read_pixel = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      checks++;
      if ({pixel_valid, word_ready, words_stored, pixel, overflow, underflow} !==
          {1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset valid=%b ready=%b words=%0d pixel=%h ovf=%b unf=%b expected 0 1 0 00 0 0",
                  pixel_valid, word_ready, words_stored, pixel, overflow, underflow);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] e [] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      write_word(32'hAABBCCDD, 1'b0);
      checks++;
      if (words_stored !== 2'd1 || word_ready !== 1'b1) begin
         errors++;
         $display("FAIL msb_after_write words=%0d ready=%b expected 1 1", words_stored, word_ready);
      end
      read_expect("msb_pixel", e, 4);
      checks++;
      if (pixel_valid !== 1'b0 || words_stored !== 2'd0 || pixel !== 8'h00) begin
         errors++;
         $display("FAIL msb_drained valid=%b words=%0d pixel=%h expected 0 0 00",
                  pixel_valid, words_stored, pixel);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] e [] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66, 8'h77, 8'h88};
      write_word(32'h11223344, 1'b1);
      write_word(32'h55667788, 1'b0);
      checks++;
      if (words_stored !== 2'd2 || word_ready !== 1'b0) begin
         errors++;
         $display("FAIL lsb_full words=%0d ready=%b expected 2 0", words_stored, word_ready);
      end
      read_expect("lsb_pixel", e, 8);
      checks++;
      if (pixel_valid !== 1'b0 || words_stored !== 2'd0) begin
         errors++;
         $display("FAIL lsb_drained valid=%b words=%0d expected 0 0", pixel_valid, words_stored);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] e [] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      write_word(32'h01020304, 1'b0);
      write_word(32'h05060708, 1'b0);
      checks++;
      if (word_ready !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_before ready=%b ovf=%b expected 0 0", word_ready, overflow);
      end
      write_word(32'h090A0B0C, 1'b0);
      checks++;
      if (overflow !== 1'b1 || words_stored !== 2'd2) begin
         errors++;
         $display("FAIL ovf_after ovf=%b words=%0d expected 1 2", overflow, words_stored);
      end
      read_expect("ovf_pixel", e, 8);
      checks++;
      if (pixel_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drained valid=%b ovf=%b expected 0 1", pixel_valid, overflow);
      end
   endtask

   task automatic test_write_at_full_pop();
      logic [7:0] e1 [] = '{8'h10, 8'h20, 8'h30};
      logic [7:0] e2 [] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (overflow !== 1'b0 || words_stored !== 2'd0) begin
         errors++;
         $display("FAIL flush_clears_ovf ovf=%b words=%0d expected 0 0", overflow, words_stored);
      end
      write_word(32'h10203040, 1'b0);
      write_word(32'h50607080, 1'b0);
      read_expect("full_head", e1, 3);
      checks++;
      if (pixel !== 8'h40 || words_stored !== 2'd2) begin
         errors++;
         $display("FAIL full_last pixel=%h words=%0d expected 40 2", pixel, words_stored);
      end
      read_pixel    = 1'b1;
      memory_data   = 32'hDEADBEEF;
      orden_lsb     = 1'b0;
      save_mem_data = 1'b1;
      tick();
      read_pixel    = 1'b0;
      save_mem_data = 1'b0;
      checks++;
      if (words_stored !== 2'd2 || overflow !== 1'b0 || pixel !== 8'h50) begin
         errors++;
         $display("FAIL full_pop_write words=%0d ovf=%b pixel=%h expected 2 0 50",
                  words_stored, overflow, pixel);
      end
      read_expect("full_tail", e2, 8);
      checks++;
      if (pixel_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drained valid=%b expected 0", pixel_valid);
      end
   endtask

   task automatic test_flush_underflow_reset();
      logic [7:0] e  [] = '{8'hCA, 8'hFE};
      logic [7:0] e3 [] = '{8'h9A};
      write_word(32'hCAFEF00D, 1'b0);
      read_expect("flush_pre", e, 2);
      flush         = 1'b1;
      memory_data   = 32'h12345678;
      save_mem_data = 1'b1;
      tick();
      flush         = 1'b0;
      save_mem_data = 1'b0;
      checks++;
      if (words_stored !== 2'd0 || pixel_valid !== 1'b0 || pixel !== 8'h00) begin
         errors++;
         $display("FAIL flush words=%0d valid=%b pixel=%h expected 0 0 00",
                  words_stored, pixel_valid, pixel);
      end
      read_pixel = 1'b1;
      tick();
      read_pixel = 1'b0;
      checks++;
      if (underflow !== 1'b1 || words_stored !== 2'd0) begin
         errors++;
         $display("FAIL underflow unf=%b words=%0d expected 1 0", underflow, words_stored);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (underflow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_clears_unf unf=%b ovf=%b expected 0 0", underflow, overflow);
      end
      // Reset in the middle of a word: the partial word and its index are lost.
      write_word(32'h11223344, 1'b0);
      read_expect("midword_pre", e, 0);
      read_pixel = 1'b1;
      tick();
      read_pixel = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (pixel_valid !== 1'b0 || words_stored !== 2'd0 || word_ready !== 1'b1) begin
         errors++;
         $display("FAIL midword_reset valid=%b words=%0d ready=%b expected 0 0 1",
                  pixel_valid, words_stored, word_ready);
      end
      write_word(32'h9ABCDEF0, 1'b0);
      read_expect("after_reset_first", e3, 1);
      checks++;
      if (pixel !== 8'hBC || words_stored !== 2'd1) begin
         errors++;
         $display("FAIL after_reset_second pixel=%h words=%0d expected BC 1", pixel, words_stored);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overflow();
      test_write_at_full_pop();
      test_flush_underflow_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
